multicycle_control: RTL
=======================

# multicycle_control

Multi-cycle control unit for the MIPS32 core. It replaces the single-cycle combinational `Control` decoder with a Moore state machine that sequences fetch, decode, execute, memory and write-back over several clocks and stalls on a memory ready handshake. It supports the same opcode set and adds illegal-opcode and memory-timeout trapping. The datapath (PC, IR, register file, ALU, memory port) is driven only by its outputs.

## Interface
- `TIMEOUT`, default 15: maximum consecutive wait cycles with `mem_ready` low before a bus error; 0 disables the timeout.
- `CNT_W`, default 4: width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `opcode`  in  6  IR[31:26]; sampled in DECODE and held stable by the IR afterwards.
- `mem_ready`  in  1  memory completes the current access in this cycle.
- `ir_write`, `pc_write`, `i_or_d`, `mem_read`, `mem_write`, `mem_to_reg`, `reg_dst`, `reg_write`, `ext_op`, `alu_src_a`, `beq`, `bne`  out  1 each  datapath strobes and selects.
- `alu_src_b`  out  2  00 = B, 01 = const 4, 10 = ext imm, 11 = ext imm<<2.
- `alu_op`  out  2  00 = add, 01 = sub, 10 = funct field, 11 = immediate op by opcode.
- `pc_src`  out  2  00 = ALU result, 01 = ALUOut (branch target), 10 = jump target.
- `illegal`  out  1  sticky; set when an unsupported opcode is decoded.
- `bus_error`  out  1  sticky; set on a memory timeout.

## Operation
- States and their transitions:
  - FETCH → DECODE.
  - DECODE → one of EXEC_R, EXEC_I, MEM_ADDR, BRANCH, JUMP or TRAP, by opcode.
  - EXEC_R → WB_R; EXEC_I → WB_I.
  - MEM_ADDR → MEM_RD (for lw) or MEM_WR (for sw).
  - MEM_RD → WB_MEM.
  - WB_R, WB_I, WB_MEM, MEM_WR, BRANCH and JUMP → FETCH.
  - TRAP → TRAP, until reset.
- Opcode map, applied in DECODE:
  - 000000 → R-type.
  - 001000 addi, 001010 slti, 001100 andi, 001101 ori, 001110 xori → EXEC_I.
  - 100011 lw, 101011 sw → MEM_ADDR.
  - 000100 beq, 000101 bne → BRANCH.
  - 000010 j → JUMP.
  - Any other opcode → TRAP with `illegal` = 1.
- Outputs are a pure function of state and the held `opcode`. Every output not listed for a state is 0.
  - FETCH: `mem_read`; `alu_src_b`=01; `alu_op`=00; `pc_src`=00. `ir_write` and `pc_write` are asserted only in the cycle `mem_ready` = 1.
  - DECODE: `alu_src_b`=11; `alu_op`=00; `ext_op`=1 (precomputes the branch target).
  - EXEC_R: `alu_src_a`; `alu_op`=10.
  - EXEC_I: `alu_src_a`; `alu_src_b`=10; `alu_op`=11.
  - MEM_ADDR: `alu_src_a`; `alu_src_b`=10; `alu_op`=00.
  - MEM_RD: `mem_read`; `i_or_d`.
  - MEM_WR: `mem_write`; `i_or_d`.
  - WB_R: `reg_write`; `reg_dst`.
  - WB_I: `reg_write`.
  - WB_MEM: `reg_write`; `mem_to_reg`.
  - BRANCH: `alu_src_a`; `alu_op`=01; `pc_src`=01; `beq` or `bne` per opcode. The datapath gates PC update with the zero flag.
  - JUMP: `pc_write`; `pc_src`=10.
  - TRAP: all strobes 0.
- `ext_op` = 1 for addi, slti, lw, sw, beq, bne; 0 for andi, ori, xori. It holds its per-opcode value in every state from EXEC onward.
- Wait states are FETCH, MEM_RD and MEM_WR. The state is held while `mem_ready` = 0 and advances on the first cycle `mem_ready` = 1.
- Wait counter:
  - Increments each cycle spent in a wait state with `mem_ready` low.
  - Clears on every state change.
  - If it reaches TIMEOUT (TIMEOUT > 0), the next state is TRAP, `bus_error` is set, and no strobe is issued.
  - If `mem_ready` rises in the same cycle the count reaches TIMEOUT, the access completes and no error is raised.

## Timing
- Reset (asynchronous, `rst_n` low): state = FETCH, counter = 0, `illegal` = 0, `bus_error` = 0.
  - During reset the outputs show FETCH decode with `mem_ready` gating: `mem_read` = 1, all other strobes 0.
- Reset asserted mid-instruction aborts it immediately. No partial write strobe survives after the reset edge.
- Latency with zero wait states:
  - R-type and I-type: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq, bne, j: 3 cycles.
- Each wait cycle adds 1 to the instruction's latency.
- `illegal` and `bus_error` are registered. They rise one cycle after the DECODE (or the timeout) cycle and stay high until reset.

## Test plan
- Reset, then addi (001000) with `mem_ready` held at 1 → states FETCH, DECODE, EXEC_I, WB_I. Required values: `reg_write` = 1 in cycle 4; `ext_op` = 1; `alu_op` = 11 in cycle 3; back to FETCH in cycle 5.
- lw (100011) with 2 wait cycles in MEM_RD → 7-cycle instruction; `mem_read` and `i_or_d` high for 3 cycles; `mem_to_reg` and `reg_write` in the last cycle.
- beq (000100) then bne (000101) → 3 cycles each. Required values: `beq` or `bne` = 1 only in BRANCH; `pc_src` = 01; `alu_op` = 01. Also j (000010) → `pc_write` = 1 and `pc_src` = 10 in cycle 3.
- Sweep opcode 0..63 → the 11 supported opcodes complete normally. Any other opcode enters TRAP; `illegal` = 1 from the next cycle, stays high, and all strobes are 0.
- TIMEOUT = 15 with `mem_ready` held low in FETCH → `bus_error` = 1 after 15 wait cycles and the FSM is in TRAP. Repeat with `mem_ready` rising exactly at count 15 → no error; DECODE follows.
- Assert `rst_n` low during MEM_WR → `mem_write` drops without waiting for a clock edge; the FSM restarts in FETCH with flags cleared.

Source files
------------

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: bundle between the multi-cycle control FSM and the MIPS32 datapath.
//   i_opcode    [5:0]  IR[31:26], held stable by the IR after FETCH
//   i_mem_ready        memory completes the current access this cycle
//   o_ir_write, o_pc_write, o_i_or_d, o_mem_read, o_mem_write, o_mem_to_reg,
//   o_reg_dst, o_reg_write, o_ext_op, o_alu_src_a, o_beq, o_bne   datapath strobes/selects
//   o_alu_src_b [1:0]  00 B, 01 const 4, 10 ext imm, 11 ext imm<<2
//   o_alu_op    [1:0]  00 add, 01 sub, 10 funct, 11 immediate op by opcode
//   o_pc_src    [1:0]  00 ALU result, 01 ALUOut, 10 jump target
//   o_illegal, o_bus_error  sticky trap flags
//   slave modport: the control unit; master modport: the datapath side
interface multicycle_control_if;
    logic [5:0] i_opcode;
    logic       i_mem_ready;
    logic       o_ir_write;
    logic       o_pc_write;
    logic       o_i_or_d;
    logic       o_mem_read;
    logic       o_mem_write;
    logic       o_mem_to_reg;
    logic       o_reg_dst;
    logic       o_reg_write;
    logic       o_ext_op;
    logic       o_alu_src_a;
    logic       o_beq;
    logic       o_bne;
    logic [1:0] o_alu_src_b;
    logic [1:0] o_alu_op;
    logic [1:0] o_pc_src;
    logic       o_illegal;
    logic       o_bus_error;

    modport slave (
        input  i_opcode, i_mem_ready,
        output o_ir_write, o_pc_write, o_i_or_d, o_mem_read, o_mem_write, o_mem_to_reg,
               o_reg_dst, o_reg_write, o_ext_op, o_alu_src_a, o_beq, o_bne,
               o_alu_src_b, o_alu_op, o_pc_src, o_illegal, o_bus_error
    );

    modport master (
        output i_opcode, i_mem_ready,
        input  o_ir_write, o_pc_write, o_i_or_d, o_mem_read, o_mem_write, o_mem_to_reg,
               o_reg_dst, o_reg_write, o_ext_op, o_alu_src_a, o_beq, o_bne,
               o_alu_src_b, o_alu_op, o_pc_src, o_illegal, o_bus_error
    );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control: Moore FSM sequencing fetch/decode/execute/memory/write-back with memory-ready stalls and traps.
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   bus     multicycle_control_if.slave: opcode and mem_ready in, datapath controls and trap flags out
//   TIMEOUT max consecutive wait cycles with mem_ready low before a bus error (0 disables)
//   CNT_W   wait counter width, 2**CNT_W > TIMEOUT
module multicycle_control #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input logic               clk,
    input logic               rst_n,
    multicycle_control_if.slave bus
);
    typedef enum logic [3:0] {
        FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR,
        WB_R, WB_I, WB_MEM, BRANCH, JUMP, TRAP
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t             r_state;
    state_t             w_next;
    state_t             w_dec;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               r_illegal;
    logic               r_bus_error;
    logic               w_legal;
    logic               w_ext;
    logic               w_wait;
    logic               w_stall;
    logic               w_timeout;
    logic               w_exec;

    // Opcode decode: target state, legality and sign/zero extension choice.
    always_comb begin
        w_dec   = TRAP;
        w_legal = 1'b1;
        w_ext   = 1'b0;
        case (bus.i_opcode)
            OP_RTYPE:                 w_dec = EXEC_R;
            OP_ADDI, OP_SLTI: begin
                w_dec = EXEC_I;
                w_ext = 1'b1;
            end
            OP_ANDI, OP_ORI, OP_XORI: w_dec = EXEC_I;
            OP_LW, OP_SW: begin
                w_dec = MEM_ADDR;
                w_ext = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                w_dec = BRANCH;
                w_ext = 1'b1;
            end
            OP_J:                     w_dec = JUMP;
            default:                  w_legal = 1'b0;
        endcase
    end

    assign w_wait    = (r_state == FETCH) || (r_state == MEM_RD) || (r_state == MEM_WR);
    assign w_stall   = w_wait && !bus.i_mem_ready;
    // A ready arriving in the cycle the count sits at TIMEOUT still completes the access.
    assign w_timeout = (TIMEOUT > 0) && w_stall && (r_cnt == CNT_W'(TIMEOUT));
    assign w_exec    = (r_state != FETCH) && (r_state != DECODE) && (r_state != TRAP);

    always_comb begin
        w_next = r_state;
        case (r_state)
            FETCH:    w_next = w_timeout ? TRAP : bus.i_mem_ready ? DECODE : FETCH;
            DECODE:   w_next = w_dec;
            EXEC_R:   w_next = WB_R;
            EXEC_I:   w_next = WB_I;
            MEM_ADDR: w_next = (bus.i_opcode == OP_LW) ? MEM_RD : MEM_WR;
            MEM_RD:   w_next = w_timeout ? TRAP : bus.i_mem_ready ? WB_MEM : MEM_RD;
            MEM_WR:   w_next = w_timeout ? TRAP : bus.i_mem_ready ? FETCH : MEM_WR;
            WB_R, WB_I, WB_MEM, BRANCH, JUMP: w_next = FETCH;
            TRAP:     w_next = TRAP;
            default:  w_next = FETCH;
        endcase
    end

    assign w_cnt_next = (w_next != r_state) ? '0 : w_stall ? r_cnt + CNT_W'(1) : r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= FETCH;
            r_cnt       <= '0;
            r_illegal   <= 1'b0;
            r_bus_error <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_cnt       <= w_cnt_next;
            r_illegal   <= r_illegal | ((r_state == DECODE) && !w_legal);
            r_bus_error <= r_bus_error | w_timeout;
        end
    end

    // Moore outputs; only the FETCH write strobes look at mem_ready, and they are
    // also masked by reset so nothing is written while rst_n is low.
    always_comb begin
        bus.o_ir_write   = 1'b0;
        bus.o_pc_write   = 1'b0;
        bus.o_i_or_d     = 1'b0;
        bus.o_mem_read   = 1'b0;
        bus.o_mem_write  = 1'b0;
        bus.o_mem_to_reg = 1'b0;
        bus.o_reg_dst    = 1'b0;
        bus.o_reg_write  = 1'b0;
        bus.o_alu_src_a  = 1'b0;
        bus.o_beq        = 1'b0;
        bus.o_bne        = 1'b0;
        bus.o_alu_src_b  = 2'b00;
        bus.o_alu_op     = 2'b00;
        bus.o_pc_src     = 2'b00;
        bus.o_ext_op     = (r_state == DECODE) || (w_exec && w_ext);
        case (r_state)
            FETCH: begin
                bus.o_mem_read  = 1'b1;
                bus.o_alu_src_b = 2'b01;
                bus.o_ir_write  = bus.i_mem_ready && rst_n;
                bus.o_pc_write  = bus.i_mem_ready && rst_n;
            end
            DECODE:   bus.o_alu_src_b = 2'b11;
            EXEC_R: begin
                bus.o_alu_src_a = 1'b1;
                bus.o_alu_op    = 2'b10;
            end
            EXEC_I: begin
                bus.o_alu_src_a = 1'b1;
                bus.o_alu_src_b = 2'b10;
                bus.o_alu_op    = 2'b11;
            end
            MEM_ADDR: begin
                bus.o_alu_src_a = 1'b1;
                bus.o_alu_src_b = 2'b10;
            end
            MEM_RD: begin
                bus.o_mem_read = 1'b1;
                bus.o_i_or_d   = 1'b1;
            end
            MEM_WR: begin
                bus.o_mem_write = 1'b1;
                bus.o_i_or_d    = 1'b1;
            end
            WB_R: begin
                bus.o_reg_write = 1'b1;
                bus.o_reg_dst   = 1'b1;
            end
            WB_I:     bus.o_reg_write = 1'b1;
            WB_MEM: begin
                bus.o_reg_write  = 1'b1;
                bus.o_mem_to_reg = 1'b1;
            end
            BRANCH: begin
                bus.o_alu_src_a = 1'b1;
                bus.o_alu_op    = 2'b01;
                bus.o_pc_src    = 2'b01;
                bus.o_beq       = (bus.i_opcode == OP_BEQ);
                bus.o_bne       = (bus.i_opcode == OP_BNE);
            end
            JUMP: begin
                bus.o_pc_write = 1'b1;
                bus.o_pc_src   = 2'b10;
            end
            default: ;
        endcase
    end

    assign bus.o_illegal   = r_illegal;
    assign bus.o_bus_error = r_bus_error;
endmodule
